// File: rtl/nlms_pkg.sv
// Shared constants for the NLMS stream pairing block: sample width, FIFO entry
// layout and statistics counter widths.
package nlms_pkg;

    localparam int ITEM_W  = 32;
    localparam int FIFO_AW = 5;

    // Each FIFO entry is {eob, last, data}.
    localparam int ENT_DATA_LSB = 0;
    localparam int ENT_LAST_BIT = ITEM_W;
    localparam int ENT_EOB_BIT  = ITEM_W + 1;
    localparam int ENT_W        = ITEM_W + 2;

    localparam int MISALIGN_W = 16;
    localparam int PAIR_CNT_W = 32;

endpackage

// File: rtl/nlms_stream_pair_if.sv
// AXI-stream style channel with end-of-burst, used for both the sample inputs
// and the paired output.
interface nlms_stream_pair_if #(
    parameter int W = 32
);
    logic [W-1:0] tdata;
    logic         tlast;
    logic         teob;
    logic         tvalid;
    logic         tready;

    modport master (output tdata, output tlast, output teob, output tvalid, input  tready);
    modport slave  (input  tdata, input  tlast, input  teob, input  tvalid, output tready);
endinterface

// File: rtl/nlms_pair_fifo.sv
// Synchronous FIFO with async reset; the read data comes straight from the
// storage array, so a written entry is visible no earlier than the next cycle.
module nlms_pair_fifo #(
    parameter int W  = 34,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wrEn_i,
    input  logic [W-1:0]  wrData_i,
    input  logic          rdEn_i,
    output logic [W-1:0]  rdData_o,
    output logic [AW:0]   level_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q;
    logic [AW-1:0] rdPtr_q;
    logic [AW:0]   level_q;

    always_ff @(posedge clk) begin
        if (wrEn_i) begin
            mem_q[wrPtr_q] <= wrData_i;
        end
    end

    // Pointers wrap naturally at the array depth; the extra level bit tells full from empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            level_q <= '0;
        end else begin
            if (wrEn_i) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (rdEn_i) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            unique case ({wrEn_i, rdEn_i})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    assign rdData_o = mem_q[rdPtr_q];
    assign level_o  = level_q;
    assign full_o   = (level_q == (AW+1)'(DEPTH));
    assign empty_o  = (level_q == '0);

endmodule

// File: rtl/nlms_stream_pair.sv
// Joins the main and aux sample streams into lock-stepped {aux,main} pairs,
// absorbing arrival skew in per-input FIFOs and counting packet misalignment.
module nlms_stream_pair #(
    parameter int ITEM_W  = nlms_pkg::ITEM_W,
    parameter int FIFO_AW = nlms_pkg::FIFO_AW
) (
    input  logic                            axis_data_clk,
    input  logic                            axis_data_rst,
    nlms_stream_pair_if.slave               s_main_axis,
    nlms_stream_pair_if.slave               s_aux_axis,
    nlms_stream_pair_if.master              m_pair_axis,
    input  logic                            clr_stats,
    output logic [nlms_pkg::MISALIGN_W-1:0] misalign_cnt,
    output logic                            misalign_err,
    output logic [nlms_pkg::PAIR_CNT_W-1:0] pair_cnt,
    output logic [FIFO_AW:0]                main_level,
    output logic [FIFO_AW:0]                aux_level
);
    import nlms_pkg::*;

    logic [ENT_W-1:0] mainEnt, auxEnt;
    logic             mainFull, mainEmpty, auxFull, auxEmpty;
    logic             mainWr, auxWr, pairValid, pop, misaligned;
    logic             mainLast, auxLast, mainEob, auxEob;

    logic [MISALIGN_W-1:0] misalignCnt_q, misalignCnt_d;
    logic                  misalignErr_q, misalignErr_d;
    logic [PAIR_CNT_W-1:0] pairCnt_q, pairCnt_d;

    // Ready depends only on FIFO state, never on the downstream ready.
    assign s_main_axis.tready = !mainFull && !axis_data_rst;
    assign s_aux_axis.tready  = !auxFull  && !axis_data_rst;
    assign mainWr = s_main_axis.tvalid && s_main_axis.tready;
    assign auxWr  = s_aux_axis.tvalid  && s_aux_axis.tready;

    nlms_pair_fifo #(.W(ENT_W), .AW(FIFO_AW)) u_main_fifo (
        .clk(axis_data_clk), .rst(axis_data_rst),
        .wrEn_i(mainWr), .wrData_i({s_main_axis.teob, s_main_axis.tlast, s_main_axis.tdata}),
        .rdEn_i(pop), .rdData_o(mainEnt), .level_o(main_level),
        .full_o(mainFull), .empty_o(mainEmpty)
    );

    nlms_pair_fifo #(.W(ENT_W), .AW(FIFO_AW)) u_aux_fifo (
        .clk(axis_data_clk), .rst(axis_data_rst),
        .wrEn_i(auxWr), .wrData_i({s_aux_axis.teob, s_aux_axis.tlast, s_aux_axis.tdata}),
        .rdEn_i(pop), .rdData_o(auxEnt), .level_o(aux_level),
        .full_o(auxFull), .empty_o(auxEmpty)
    );

    assign mainLast   = mainEnt[ENT_LAST_BIT];
    assign auxLast    = auxEnt[ENT_LAST_BIT];
    assign mainEob    = mainEnt[ENT_EOB_BIT];
    assign auxEob     = auxEnt[ENT_EOB_BIT];
    assign pairValid  = !mainEmpty && !auxEmpty;
    assign pop        = pairValid && m_pair_axis.tready;
    assign misaligned = (mainLast != auxLast);

    // Output fields are forced to zero when no pair is held so reset shows all-zero outputs.
    assign m_pair_axis.tvalid = pairValid;
    assign m_pair_axis.tdata  = pairValid ? {auxEnt[ENT_DATA_LSB +: ITEM_W], mainEnt[ENT_DATA_LSB +: ITEM_W]} : '0;
    assign m_pair_axis.tlast  = pairValid && mainLast;
    assign m_pair_axis.teob   = pairValid && mainLast && (mainEob || auxEob);

    // A clear in the same cycle as a pop takes priority over the increment.
    always_comb begin
        misalignCnt_d = misalignCnt_q;
        misalignErr_d = misalignErr_q;
        pairCnt_d     = pairCnt_q;
        if (clr_stats) begin
            misalignCnt_d = '0;
            misalignErr_d = 1'b0;
            pairCnt_d     = '0;
        end else if (pop) begin
            pairCnt_d = pairCnt_q + 1'b1;
            if (misaligned) begin
                misalignErr_d = 1'b1;
                if (misalignCnt_q != '1) begin
                    misalignCnt_d = misalignCnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge axis_data_clk or posedge axis_data_rst) begin
        if (axis_data_rst) begin
            misalignCnt_q <= '0;
            misalignErr_q <= 1'b0;
            pairCnt_q     <= '0;
        end else begin
            misalignCnt_q <= misalignCnt_d;
            misalignErr_q <= misalignErr_d;
            pairCnt_q     <= pairCnt_d;
        end
    end

    assign misalign_cnt = misalignCnt_q;
    assign misalign_err = misalignErr_q;
    assign pair_cnt     = pairCnt_q;

endmodule

// File: tb/tb_nlms_stream_pair.sv
// Scoreboard bench for nlms_stream_pair: directed packets are queued as expected
// pairs and a monitor compares every transferred pair against the queue.
module tb_nlms_stream_pair;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        clrStats  = 1'b0;
    logic        pairReady = 1'b0;
    logic [15:0] misalignCnt;
    logic        misalignErr;
    logic [31:0] pairCnt;
    logic [5:0]  mainLevel;
    logic [5:0]  auxLevel;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct packed {
        logic [63:0] data;
        logic        last;
        logic        eob;
    } pair_t;

    pair_t sb[$];

    always #5 clk = ~clk;

    nlms_stream_pair_if #(.W(32)) mainIf ();
    nlms_stream_pair_if #(.W(32)) auxIf ();
    nlms_stream_pair_if #(.W(64)) pairIf ();

    assign pairIf.tready = pairReady;

    nlms_stream_pair dut (
        .axis_data_clk(clk),
        .axis_data_rst(rst),
        .s_main_axis(mainIf),
        .s_aux_axis(auxIf),
        .m_pair_axis(pairIf),
        .clr_stats(clrStats),
        .misalign_cnt(misalignCnt),
        .misalign_err(misalignErr),
        .pair_cnt(pairCnt),
        .main_level(mainLevel),
        .aux_level(auxLevel)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake seen at the falling edge completes on the next rising edge.
    always @(negedge clk) begin
        pair_t exp;
        if (!rst && pairIf.tvalid && pairIf.tready) begin
            if (sb.size() == 0) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL unexpectedPair: got %0h, expected no pair", pairIf.tdata);
            end else begin
                exp = sb.pop_front();
                checkOutput("pairData", pairIf.tdata, exp.data);
                checkOutput("pairLastEob", {62'd0, pairIf.tlast, pairIf.teob}, {62'd0, exp.last, exp.eob});
            end
        end
    end

    task automatic syncEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit isAux, input logic [31:0] d, input logic l, input logic e);
        bit acc = 1'b0;
        int n   = 0;
        if (isAux) begin
            auxIf.tdata = d; auxIf.tlast = l; auxIf.teob = e; auxIf.tvalid = 1'b1;
        end else begin
            mainIf.tdata = d; mainIf.tlast = l; mainIf.teob = e; mainIf.tvalid = 1'b1;
        end
        while (!acc && n < 500) begin
            @(negedge clk);
            acc = isAux ? auxIf.tready : mainIf.tready;
            n++;
        end
        if (!acc) checkOutput("inputTimeout", 64'd0, 64'd1);
        syncEdge();
        if (isAux) auxIf.tvalid = 1'b0;
        else       mainIf.tvalid = 1'b0;
    endtask

    task automatic sendStream(input bit isAux, input int n, input logic [31:0] base,
                              input int pktLen, input int eobIdx);
        for (int i = 0; i < n; i++) begin
            applyStimulus(isAux, base + 32'(i), (i % pktLen) == pktLen - 1, i == eobIdx);
        end
    endtask

    function automatic void expectPairs(input int n, input logic [31:0] mBase, input logic [31:0] aBase,
                                        input int mPkt, input int aPkt, input int mEob, input int aEob);
        pair_t p;
        logic  mLast;
        for (int i = 0; i < n; i++) begin
            mLast  = (i % mPkt) == mPkt - 1;
            p.data = {aBase + 32'(i), mBase + 32'(i)};
            p.last = mLast;
            p.eob  = mLast && ((i == mEob) || (i == aEob));
            sb.push_back(p);
        end
    endfunction

    task automatic waitDrain();
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", 64'(sb.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        mainIf.tdata = '0; mainIf.tlast = 0; mainIf.teob = 0; mainIf.tvalid = 0;
        auxIf.tdata  = '0; auxIf.tlast  = 0; auxIf.teob  = 0; auxIf.tvalid  = 0;

        // Reset state
        repeat (3) syncEdge();
        checkOutput("rstMainReady", {63'd0, mainIf.tready}, 64'd0);
        checkOutput("rstPairValid", {63'd0, pairIf.tvalid}, 64'd0);
        checkOutput("rstLevels", {52'd0, mainLevel, auxLevel}, 64'd0);
        checkOutput("rstStats", {15'd0, misalignErr, misalignCnt, pairCnt}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("releaseReady", {62'd0, mainIf.tready, auxIf.tready}, 64'd3);
        syncEdge();

        // Lock-step packets
        pairReady = 1'b1;
        expectPairs(8, 32'h0, 32'h100, 8, 8, -1, -1);
        fork
            sendStream(0, 8, 32'h0, 8, -1);
            sendStream(1, 8, 32'h100, 8, -1);
        join
        waitDrain();
        checkOutput("lockMisalign", {47'd0, misalignErr, misalignCnt}, 64'd0);
        checkOutput("lockPairCnt", 64'(pairCnt), 64'd8);
        syncEdge();

        // Skew: main runs a full FIFO ahead of aux
        expectPairs(32, 32'h200, 32'h300, 32, 32, -1, -1);
        sendStream(0, 32, 32'h200, 32, -1);
        @(negedge clk);
        checkOutput("skewMainLevel", 64'(mainLevel), 64'd32);
        checkOutput("skewMainReady", {63'd0, mainIf.tready}, 64'd0);
        checkOutput("skewPairValid", {63'd0, pairIf.tvalid}, 64'd0);
        syncEdge();
        sendStream(1, 32, 32'h300, 32, -1);
        waitDrain();
        checkOutput("skewPairCnt", 64'(pairCnt), 64'd40);
        checkOutput("skewLevels", {52'd0, mainLevel, auxLevel}, 64'd0);
        syncEdge();

        // Backpressure, then random downstream ready
        pairReady = 1'b0;
        expectPairs(8, 32'h0, 32'h100, 8, 8, -1, -1);
        fork
            sendStream(0, 8, 32'h0, 8, -1);
            sendStream(1, 8, 32'h100, 8, -1);
        join
        repeat (10) begin
            @(negedge clk);
            checkOutput("holdData", pairIf.tdata, sb[0].data);
            checkOutput("holdLast", {63'd0, pairIf.tlast}, {63'd0, sb[0].last});
        end
        checkOutput("holdPairCnt", 64'(pairCnt), 64'd40);
        checkOutput("holdLevel", 64'(mainLevel), 64'd8);
        syncEdge();
        for (int n = 0; n < 500 && sb.size() != 0; n++) begin
            pairReady = 1'($urandom_range(0, 1));
            syncEdge();
        end
        pairReady = 1'b1;
        waitDrain();
        checkOutput("randPairCnt", 64'(pairCnt), 64'd48);
        syncEdge();

        // Misalignment: 4-sample main packets against 5-sample aux packets
        expectPairs(20, 32'h400, 32'h500, 4, 5, -1, -1);
        fork
            sendStream(0, 20, 32'h400, 4, -1);
            sendStream(1, 20, 32'h500, 5, -1);
        join
        waitDrain();
        checkOutput("misCnt", 64'(misalignCnt), 64'd7);
        checkOutput("misErr", {63'd0, misalignErr}, 64'd1);
        checkOutput("misPairCnt", 64'(pairCnt), 64'd68);
        syncEdge();

        // Clear coinciding with a pop
        pairReady = 1'b0;
        expectPairs(1, 32'h600, 32'h700, 1, 1, -1, -1);
        fork
            sendStream(0, 1, 32'h600, 1, -1);
            sendStream(1, 1, 32'h700, 1, -1);
        join
        pairReady = 1'b1;
        clrStats  = 1'b1;
        syncEdge();
        clrStats  = 1'b0;
        @(negedge clk);
        checkOutput("clrStats", {15'd0, misalignErr, misalignCnt, pairCnt}, 64'd0);
        checkOutput("clrPopped", 64'(sb.size()), 64'd0);
        syncEdge();

        // End of burst flagged by aux only
        expectPairs(4, 32'h800, 32'h900, 4, 4, -1, 3);
        fork
            sendStream(0, 4, 32'h800, 4, -1);
            sendStream(1, 4, 32'h900, 4, 3);
        join
        waitDrain();
        checkOutput("eobPairCnt", 64'(pairCnt), 64'd4);
        syncEdge();

        // Reset mid-operation
        pairReady = 1'b0;
        fork
            sendStream(0, 5, 32'hC00, 8, -1);
            sendStream(1, 3, 32'hD00, 8, -1);
        join
        @(negedge clk);
        checkOutput("preRstLevels", {52'd0, mainLevel, auxLevel}, {52'd0, 6'd5, 6'd3});
        checkOutput("preRstValid", {63'd0, pairIf.tvalid}, 64'd1);
        syncEdge();
        rst = 1'b1;
        #1;
        checkOutput("midRstOut", {pairIf.tdata[62:0], pairIf.tvalid}, 64'd0);
        checkOutput("midRstState", {19'd0, mainLevel, auxLevel, pairCnt, mainIf.tready}, 64'd0);
        repeat (2) syncEdge();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("postRstLevels", {52'd0, mainLevel, auxLevel}, 64'd0);
        checkOutput("postRstReady", {61'd0, mainIf.tready, auxIf.tready, pairIf.tvalid}, 64'd6);

        // Pair counter wrap
        force dut.pairCnt_d = 32'hFFFF_FFFF;
        syncEdge();
        release dut.pairCnt_d;
        @(negedge clk);
        checkOutput("wrapPreset", 64'(pairCnt), 64'hFFFF_FFFF);
        syncEdge();
        pairReady = 1'b1;
        expectPairs(1, 32'hE00, 32'hF00, 1, 1, -1, -1);
        fork
            sendStream(0, 1, 32'hE00, 1, -1);
            sendStream(1, 1, 32'hF00, 1, -1);
        join
        waitDrain();
        checkOutput("wrapPairCnt", 64'(pairCnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
